// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register sequencer.
// Holds the FSM state encoding, the register shift codes and the counter-width helper.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        CAPT  = 2'd3
    } state_t;

    localparam logic [1:0] SH_HOLD  = 2'b00;
    localparam logic [1:0] SH_RIGHT = 2'b01;
    localparam logic [1:0] SH_LEFT  = 2'b10;

    // Bit-counter width; never below one bit so a degenerate NBITS=1 still builds.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Client-side handshake of the sequencer.
// Carries start/dir/load_data towards the controller and busy/done/rx_data back to the client.
interface shift_seq_ctrl_if #(
    parameter int unsigned NBITS = 8
);
    logic             start;
    logic             dir;
    logic [NBITS-1:0] load_data;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] rx_data;

    modport master (
        output start, dir, load_data,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, dir, load_data,
        output busy, done, rx_data
    );
endinterface

// File: rtl/shift_bitcnt.sv
// Clearable up-counter that flags the last bit of a transfer.
// tc_c is high while the count equals NBITS-1.
module shift_bitcnt
    import shift_seq_pkg::*;
#(
    parameter int unsigned NBITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc_c
);
    localparam int unsigned CW = cnt_width(NBITS);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc_c = (count == CW'(NBITS - 1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external parallel/serial shift register: load, NBITS shifts, capture.
// The register sits beside this block; this block only drives its control inputs.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_ctrl_if.slave  bus,
    input  logic             ser_in,
    output logic             ser_out,
    output logic [1:0]       sh_shift,
    output logic             sh_datain,
    output logic [NBITS-1:0] sh_regin,
    input  logic [NBITS-1:0] sh_regout,
    input  logic             sh_dataout
);
    state_t           state;
    logic             dir_q;
    logic [NBITS-1:0] data_q;
    logic [NBITS-1:0] rx_q;
    logic             done_q;
    logic             tc_c;
    logic             cnt_clear_c;
    logic             cnt_en_c;

    assign cnt_clear_c = (state == LOAD);
    assign cnt_en_c    = (state == SHIFT);

    shift_bitcnt #(
        .NBITS (NBITS)
    ) u_bitcnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear_c),
        .en    (cnt_en_c),
        .tc_c  (tc_c)
    );

    // Sequencing FSM; request fields are latched once so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dir_q  <= 1'b0;
            data_q <= '0;
            rx_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        dir_q  <= bus.dir;
                        data_q <= bus.load_data;
                        state  <= LOAD;
                    end
                end
                LOAD:  state <= SHIFT;
                SHIFT: begin
                    if (tc_c) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    rx_q   <= sh_regout;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register control decode; outside LOAD the register is fed its own value so it holds.
    always_comb begin
        sh_shift  = SH_HOLD;
        sh_regin  = sh_regout;
        sh_datain = 1'b0;
        ser_out   = 1'b0;
        unique case (state)
            LOAD: sh_regin = data_q;
            SHIFT: begin
                sh_shift  = dir_q ? SH_LEFT : SH_RIGHT;
                sh_datain = ser_in;
                ser_out   = sh_dataout;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;

endmodule
